cpu_fsm: RTL
============

# cpu_fsm

Instruction sequencer for the 16-bit datapath built around the 8×16 register file. It holds the current instruction in an internal instruction register and decodes it. It then steps the register file read/write ports, the A/B/C/status pipeline registers and the ALU/shifter selects through a Moore state machine, one micro-step per clock. It sits between the instruction source (switches or memory) and the datapath. `w` tells the source when a new instruction may be loaded and started.

## Interface
- No parameters; widths are fixed by the ISA (16-bit instructions, 3-bit register numbers).
- `clk` input 1: rising-edge clock for all state.
- `reset` input 1: synchronous, active-high reset.
- `instr` input 16: instruction word presented for capture.
- `load` input 1: capture `instr` into IR at the next edge; honoured only while `w`=1.
- `s` input 1: start execution of the IR contents; sampled only in WAIT.
- `w` output 1: 1 only in WAIT.
- `readnum` output 3: register-file read select.
- `writenum` output 3: register-file write select.
- `write` output 1: register-file write enable.
- `loada`, `loadb`, `loadc`, `loads` outputs 1 each: load enables for the A, B, C and status registers.
- `asel` output 1: 1 forces ALU input A to 0.
- `bsel` output 1: 1 selects `sximm5` for input B; always 0 in this ISA subset.
- `vsel` output 1: write-back source; 0 = C, 1 = `sximm8`.
- `shift` output 2: IR[4:3].
- `aluop` output 2: IR[12:11].
- `sximm8` output 16: IR[7:0] sign-extended.
- `illegal` output 1: sticky undefined-opcode flag (see Configuration).

## Operation
- IR fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Supported instructions:
  - MOV Rn,#imm8 (110/10): Rn ← sximm8.
  - MOV Rd,Rm (110/00): Rd ← sh(Rm).
  - ADD (101/00): Rd ← Rn + sh(Rm).
  - CMP (101/01): status ← flags of Rn − sh(Rm); no register write.
  - AND (101/10): Rd ← Rn & sh(Rm).
  - MVN (101/11): Rd ← ~sh(Rm).
- States and transitions:
  - WAIT → DECODE when s=1; otherwise stay in WAIT.
  - DECODE → WRITE_IMM for MOV-imm; → GET_B for MOV-reg and MVN; → GET_A for ADD, CMP and AND; → undefined handling for any other opcode/op.
  - WRITE_IMM: `write`=1, `writenum`=Rn, `vsel`=1 → WAIT.
  - GET_A: `readnum`=Rn, `loada`=1 → GET_B.
  - GET_B: `readnum`=Rm, `loadb`=1 → EXEC.
  - EXEC: `asel`=1 for MOV-reg and MVN. CMP asserts `loads`=1 → WAIT. All others assert `loadc`=1 → WRITE_REG.
  - WRITE_REG: `write`=1, `writenum`=Rd, `vsel`=0 → WAIT.
- All strobes are Moore outputs decoded from state and IR and are 0 in any state not listed for them.
- `readnum` and `writenum` are 0 outside the states that drive them.
- `shift`, `aluop` and `sximm8` are continuous decodes of IR.
- IR update rule: IR ← `instr` on an edge with `load`=1 and `w`=1. `load` in any other state is ignored, so IR is stable for the whole instruction.
- Simultaneous `load` and `s` in WAIT: IR captures the new word and DECODE uses that new word.

## Timing
- Reset: state = WAIT, IR = 16'h0000, `illegal` = 0.
  - Reset therefore gives `w`=1, all strobes 0, `readnum`=`writenum`=0 and `sximm8`=0.
- Reset mid-instruction aborts at the next edge; no further `write` pulse is issued.
- Latency is counted in edges from the edge that samples s=1 until `w` returns to 1:
  - MOV-imm: 3.
  - CMP: 5.
  - MOV-reg and MVN: 5.
  - ADD and AND: 6.
- `write` is high for exactly one cycle per writing instruction.
- s held high keeps re-executing IR back-to-back, with one WAIT cycle between instructions.

## Configuration
- `CPU_FSM_ILLEGAL_TRAP_EN` defined: an undefined opcode/op in DECODE goes to HALT. HALT sets `illegal`=1, keeps `w`=0 and ignores `s` and `load`; only `reset` exits it.
- `CPU_FSM_ILLEGAL_TRAP_EN` undefined: an undefined opcode/op goes DECODE → WAIT with no strobes, and `illegal` is tied to 0.

## Test plan
- Reset, then load 16'hD107 (MOV R1,#7) and pulse s: `write`=1 with `writenum`=1, `vsel`=1, `sximm8`=16'h0007 on the 3rd cycle; `w`=1 after 3 edges.
- MOV R0,#-2 (16'hD0FE): `sximm8`=16'hFFFE.
- ADD R2,R1,R0 (16'hA140): check the strobe sequence. `loada` with `readnum`=1, then `loadb` with `readnum`=0, then `loadc`, then `write` with `writenum`=2. `w`=1 after 6 edges.
- CMP R1,R0 (16'hA900): `loads`=1 in EXEC; `write` never asserts; `w` back after 5 edges.
- Pulse `load` with a new word during GET_B: IR is unchanged and `sximm8`/`aluop` are unaffected. Then assert `reset` in EXEC: next cycle `w`=1 and there is no `write` pulse.
- Load 16'hE000 (undefined) and pulse s:
  - With the macro: `illegal`=1 and `w`=0 held until `reset`.
  - Without the macro: `w`=1 after 2 edges and `illegal`=0.

Source files
------------

// File: rtl/cpu_fsm_if.sv
// Instruction-source / datapath control bundle for cpu_fsm.
// master = the environment (instruction source + datapath); slave = the sequencer.
interface cpu_fsm_if;
  logic [15:0] instr;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic [15:0] sximm8;
  logic        illegal;

  modport master (
    output instr, load, s,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, shift, aluop, sximm8, illegal
  );

  modport slave (
    input  instr, load, s,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, shift, aluop, sximm8, illegal
  );
endinterface

// File: rtl/cpu_fsm.sv
// Moore instruction sequencer driving the 8x16 register-file datapath, one micro-step per clock.
// Optional CPU_FSM_ILLEGAL_TRAP_EN: undefined instructions halt the machine and raise `illegal`.
module cpu_fsm (
  input  logic      clk,
  input  logic      reset,
  cpu_fsm_if.slave  bus
);

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_WRITE_IMM = 3'd2;
  localparam logic [2:0] S_GET_A     = 3'd3;
  localparam logic [2:0] S_GET_B     = 3'd4;
  localparam logic [2:0] S_EXEC      = 3'd5;
  localparam logic [2:0] S_WRITE_REG = 3'd6;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_HALT      = 3'd7;
`endif

  logic [2:0]  state_reg, state_next;
  logic [15:0] ir_reg;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp, skip_a;

  assign opcode = ir_reg[15:13];
  assign op     = ir_reg[12:11];
  assign rn     = ir_reg[10:8];
  assign rd     = ir_reg[7:5];
  assign rm     = ir_reg[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);
  // Single-operand instructions never read Rn and pass 0 as ALU input A.
  assign skip_a     = is_mov_reg || is_mvn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_WAIT;
      ir_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      // IR only changes while idle, so it is stable across a whole instruction.
      if (bus.load && (state_reg == S_WAIT))
        ir_reg <= bus.instr;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT:      if (bus.s) state_next = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)
          state_next = S_WRITE_IMM;
        else if (skip_a)
          state_next = S_GET_B;
        else if (is_alu)
          state_next = S_GET_A;
        else
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
          state_next = S_HALT;
`else
          state_next = S_WAIT;
`endif
      end
      S_WRITE_IMM: state_next = S_WAIT;
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_EXEC;
      S_EXEC:      state_next = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_next = S_WAIT;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
      S_HALT:      state_next = S_HALT;
`endif
      default:     state_next = S_WAIT;
    endcase
  end

  logic [2:0] readnum_c, writenum_c;
  logic       write_c, loada_c, loadb_c, loadc_c, loads_c, asel_c, vsel_c;

  always_comb begin
    readnum_c  = 3'd0;
    writenum_c = 3'd0;
    write_c    = 1'b0;
    loada_c    = 1'b0;
    loadb_c    = 1'b0;
    loadc_c    = 1'b0;
    loads_c    = 1'b0;
    asel_c     = 1'b0;
    vsel_c     = 1'b0;
    case (state_reg)
      S_WRITE_IMM: begin
        write_c    = 1'b1;
        writenum_c = rn;
        vsel_c     = 1'b1;
      end
      S_GET_A: begin
        readnum_c = rn;
        loada_c   = 1'b1;
      end
      S_GET_B: begin
        readnum_c = rm;
        loadb_c   = 1'b1;
      end
      S_EXEC: begin
        asel_c  = skip_a;
        loads_c = is_cmp;
        loadc_c = !is_cmp;
      end
      S_WRITE_REG: begin
        write_c    = 1'b1;
        writenum_c = rd;
      end
      default: ;
    endcase
  end

  logic [15:0] sximm8;
  assign sximm8[7:0] = ir_reg[7:0];
  for (genvar gi = 8; gi < 16; gi++) begin : g_sext
    assign sximm8[gi] = ir_reg[7];
  end

  assign bus.w        = (state_reg == S_WAIT);
  assign bus.readnum  = readnum_c;
  assign bus.writenum = writenum_c;
  assign bus.write    = write_c;
  assign bus.loada    = loada_c;
  assign bus.loadb    = loadb_c;
  assign bus.loadc    = loadc_c;
  assign bus.loads    = loads_c;
  assign bus.asel     = asel_c;
  assign bus.bsel     = 1'b0;
  assign bus.vsel     = vsel_c;
  assign bus.shift    = ir_reg[4:3];
  assign bus.aluop    = ir_reg[12:11];
  assign bus.sximm8   = sximm8;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
  // HALT is only left through reset, so this is sticky by construction.
  assign bus.illegal  = (state_reg == S_HALT);
`else
  assign bus.illegal  = 1'b0;
`endif

endmodule
